// File: rtl/store_buffer.sv
// Write-posting store FIFO in front of a single synchronous-write data memory port.
// Queued stores drain in order while the port is free, and loads that hit a pending word are stalled.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int IDX_HI = 13
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       st_valid_in,
  input  logic [31:0]                st_addr_in,
  input  logic [31:0]                st_data_in,
  input  logic [2:0]                 st_func3_in,
  output logic                       st_ready_out,
  input  logic                       ld_req_in,
  input  logic [31:0]                ld_addr_in,
  input  logic [2:0]                 ld_func3_in,
  output logic                       ld_stall_out,
  input  logic                       mem_ready_in,
  output logic [31:0]                mem_addr_out,
  output logic [31:0]                mem_data_out,
  output logic [2:0]                 mem_func3_out,
  output logic                       mem_write_out,
  output logic                       misalign_err_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out,
  output logic                       empty_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_addr  [DEPTH];
  logic [31:0]   r_data  [DEPTH];
  logic [2:0]    r_func3 [DEPTH];
  logic          r_valid [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_misalign;

  logic             w_full;
  logic             w_accept;
  logic             w_aligned;
  logic             w_enq;
  logic             w_misalign;
  logic             w_drain;
  logic [DEPTH-1:0] w_hit;

  assign w_full       = (r_count == CW'(DEPTH));
  assign st_ready_out = !w_full && !ld_req_in;
  assign w_accept     = st_valid_in && st_ready_out;

  always_comb begin
    w_aligned  = 1'b0;
    w_misalign = 1'b0;
    case (st_func3_in)
      3'b000:  w_aligned = 1'b1;
      3'b001:  begin
        w_aligned  = !st_addr_in[0];
        w_misalign = st_addr_in[0];
      end
      3'b010:  begin
        w_aligned  = (st_addr_in[1:0] == 2'b00);
        w_misalign = (st_addr_in[1:0] != 2'b00);
      end
      default: ;
    endcase
  end

  assign w_enq = w_accept && w_aligned;

  // Word-granular hazard compare against every live entry; no forwarding.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign w_hit[gi] = r_valid[gi] && (r_addr[gi][IDX_HI:2] == ld_addr_in[IDX_HI:2]);
    end
  endgenerate

  assign ld_stall_out = ld_req_in && (|w_hit);

  // A stalled load leaves the port idle, so drain keeps running and the stall resolves.
  assign w_drain = (r_count != '0) && mem_ready_in && (!ld_req_in || ld_stall_out);

  assign mem_write_out    = w_drain;
  assign mem_addr_out     = w_drain ? r_addr[r_rd_ptr]  : ld_addr_in;
  assign mem_func3_out    = w_drain ? r_func3[r_rd_ptr] : ld_func3_in;
  assign mem_data_out     = r_data[r_rd_ptr];
  assign misalign_err_out = r_misalign;
  assign count_out        = r_count;
  assign empty_out        = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr]  <= st_addr_in;
      r_data[r_wr_ptr]  <= st_data_in;
      r_func3[r_wr_ptr] <= st_func3_in;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_valid[gi] <= 1'b0;
        end else if (w_enq && (r_wr_ptr == PW'(gi))) begin
          r_valid[gi] <= 1'b1;
        end else if (w_drain && (r_rd_ptr == PW'(gi))) begin
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_enq)   r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_drain) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= r_count + CW'(w_enq) - CW'(w_drain);
      r_misalign <= w_accept && w_misalign;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, checked each cycle
// against a queue-based model of the posting buffer.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int IDX_HI = 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid_in;
  logic [31:0] st_addr_in;
  logic [31:0] st_data_in;
  logic [2:0]  st_func3_in;
  logic        st_ready_out;
  logic        ld_req_in;
  logic [31:0] ld_addr_in;
  logic [2:0]  ld_func3_in;
  logic        ld_stall_out;
  logic        mem_ready_in;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [2:0]  mem_func3_out;
  logic        mem_write_out;
  logic        misalign_err_out;
  logic [2:0]  count_out;
  logic        empty_out;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  ent_t q[$];
  logic exp_mis;
  int   n_pass;
  int   n_total;

  store_buffer #(.DEPTH(DEPTH), .IDX_HI(IDX_HI)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .st_valid_in      (st_valid_in),
    .st_addr_in       (st_addr_in),
    .st_data_in       (st_data_in),
    .st_func3_in      (st_func3_in),
    .st_ready_out     (st_ready_out),
    .ld_req_in        (ld_req_in),
    .ld_addr_in       (ld_addr_in),
    .ld_func3_in      (ld_func3_in),
    .ld_stall_out     (ld_stall_out),
    .mem_ready_in     (mem_ready_in),
    .mem_addr_out     (mem_addr_out),
    .mem_data_out     (mem_data_out),
    .mem_func3_out    (mem_func3_out),
    .mem_write_out    (mem_write_out),
    .misalign_err_out (misalign_err_out),
    .count_out        (count_out),
    .empty_out        (empty_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, compare outputs against the model, then advance the model at posedge.
  task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                     input logic lr, input logic [31:0] la, input logic [2:0] lf, input logic mr);
    bit   stall;
    bit   drain;
    bit   rdy;
    bit   mis;
    ent_t head;
    ent_t e;
    st_valid_in  = sv;
    st_addr_in   = sa;
    st_data_in   = sd;
    st_func3_in  = sf;
    ld_req_in    = lr;
    ld_addr_in   = la;
    ld_func3_in  = lf;
    mem_ready_in = mr;
    #1;
    stall = 0;
    if (lr) foreach (q[i]) if (q[i].a[IDX_HI:2] == la[IDX_HI:2]) stall = 1;
    rdy   = (q.size() < DEPTH) && !lr;
    drain = (q.size() > 0) && mr && (!lr || stall);
    head  = (q.size() > 0) ? q[0] : '0;
    chk("st_ready", {31'd0, st_ready_out}, {31'd0, rdy});
    chk("ld_stall", {31'd0, ld_stall_out}, {31'd0, stall});
    chk("mem_write", {31'd0, mem_write_out}, {31'd0, drain});
    chk("mem_addr", mem_addr_out, drain ? head.a : la);
    chk("mem_func3", {29'd0, mem_func3_out}, {29'd0, (drain ? head.f : lf)});
    if (drain) chk("mem_data", mem_data_out, head.d);
    chk("count", {29'd0, count_out}, q.size());
    chk("empty", {31'd0, empty_out}, {31'd0, (q.size() == 0)});
    chk("misalign", {31'd0, misalign_err_out}, {31'd0, exp_mis});
    @(posedge clk);
    if (drain) begin
      $display("write addr=%h data=%h func3=%b", head.a, head.d, head.f);
      void'(q.pop_front());
    end
    mis = 0;
    if (sv && rdy) begin
      e.a = sa; e.d = sd; e.f = sf;
      case (sf)
        3'b000: q.push_back(e);
        3'b001: if (sa[0]) mis = 1; else q.push_back(e);
        3'b010: if (sa[1:0] != 2'b00) mis = 1; else q.push_back(e);
        default: ;
      endcase
    end
    exp_mis = mis;
    @(negedge clk);
  endtask

  task automatic idle(input logic mr);
    cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000, mr);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    exp_mis = 0;
    reset_n = 1'b0;
    st_valid_in = 1'b0; st_addr_in = '0; st_data_in = '0; st_func3_in = '0;
    ld_req_in = 1'b0; ld_addr_in = '0; ld_func3_in = '0; mem_ready_in = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_count", {29'd0, count_out}, 32'd0);
    chk("rst_empty", {31'd0, empty_out}, 32'd1);
    chk("rst_write", {31'd0, mem_write_out}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err_out}, 32'd0);
    chk("rst_stall", {31'd0, ld_stall_out}, 32'd0);
    chk("rst_ready_noload", {31'd0, st_ready_out}, 32'd1);
    ld_req_in = 1'b1;
    #1;
    chk("rst_ready_load", {31'd0, st_ready_out}, 32'd0);
    ld_req_in = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Single aligned word store drains on the next cycle.
    cyc(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0, 3'b000, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Fill to full with the port busy, then release it while a fifth store waits.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + 4 * i, 32'hA000 + i, 3'b010, 1'b0, 32'h0, 3'b000, 1'b0);
    cyc(1'b1, 32'h20, 32'hA004, 3'b010, 1'b0, 32'h0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h20, 32'hA004, 3'b010, 1'b0, 32'h0, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Load hitting a pending byte store stalls until that store drains.
    cyc(1'b1, 32'h105, 32'h000000AB, 3'b000, 1'b0, 32'h0, 3'b000, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h104, 3'b010, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h104, 3'b010, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h104, 3'b010, 1'b1);

    // Load to a different word takes the port; the pending store waits.
    cyc(1'b1, 32'h104, 32'h12345678, 3'b010, 1'b0, 32'h0, 3'b000, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h108, 3'b010, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Misaligned SW/SH pulse the error once; an unknown funct3 is silently consumed.
    cyc(1'b1, 32'h102, 32'h11111111, 3'b010, 1'b0, 32'h0, 3'b000, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b1, 32'h103, 32'h2222, 3'b001, 1'b0, 32'h0, 3'b000, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b1, 32'h100, 32'h3333, 3'b011, 1'b0, 32'h0, 3'b000, 1'b0);
    idle(1'b0);
    cyc(1'b1, 32'h102, 32'h4444, 3'b001, 1'b0, 32'h0, 3'b000, 1'b0);
    idle(1'b1);

    // Asynchronous reset in the middle of a cycle with three stores pending.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 4 * i, 32'hB000 + i, 3'b010, 1'b0, 32'h0, 3'b000, 1'b0);
    mem_ready_in = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_count", {29'd0, count_out}, 32'd0);
    chk("midrst_write", {31'd0, mem_write_out}, 32'd0);
    chk("midrst_empty", {31'd0, empty_out}, 32'd1);
    chk("midrst_ready", {31'd0, st_ready_out}, 32'd1);
    q.delete();
    exp_mis = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Random traffic on a narrow address window to provoke hazards and misalignment.
    for (int n = 0; n < 400; n++) begin
      logic        sv;
      logic [31:0] sa;
      logic [31:0] sd;
      logic [2:0]  sf;
      logic        lr;
      logic [31:0] la;
      logic [2:0]  lf;
      logic        mr;
      sv = ($urandom_range(0, 99) < 60);
      sa = 32'h300 + $urandom_range(0, 23);
      sd = $urandom;
      sf = 3'($urandom_range(0, 3));
      lr = ($urandom_range(0, 99) < 30);
      la = 32'h300 + $urandom_range(0, 23);
      lf = 3'($urandom_range(0, 5));
      mr = ($urandom_range(0, 99) < 55);
      cyc(sv, sa, sd, sf, lr, la, lf, mr);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
